// File: rtl/hit_scan.sv
// hit_scan: walks the enemy formation one enemy per clock, testing every bullet
// against it in parallel; tracks per-enemy health and reports kills.
`default_nettype none

module hit_scan #(
  parameter int BulletCount = 2,
  parameter int EnemyCount  = 40,
  parameter int MaxHp       = 1,
  parameter int EnemyW      = 16,
  parameter int EnemyH      = 16,
  parameter int BulletBoxX0 = 5,
  parameter int BulletBoxW  = 2,
  parameter int BulletBoxY0 = 3,
  parameter int BulletBoxH  = 8,
  parameter int ScreenH     = 480
) (
  input  logic                                  clk_i,
  input  logic                                  reset_ni,
  input  logic                                  frame_start_i,
  input  logic                                  revive_i,
  input  logic [BulletCount-1:0]                bullet_valid_i,
  input  logic [BulletCount-1:0][9:0]           bullet_xpos_i,
  input  logic [BulletCount-1:0][9:0]           bullet_ypos_i,
  input  logic [EnemyCount-1:0][9:0]            enemy_xpos_i,
  input  logic [EnemyCount-1:0][9:0]            enemy_ypos_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [BulletCount-1:0]                bhit_o,
  output logic [EnemyCount-1:0]                 ehit_o,
  output logic                                  kill_valid_o,
  output logic [$clog2(EnemyCount)-1:0]         kill_idx_o
);

  localparam int IdxW = $clog2(EnemyCount);
  localparam logic [3:0] HpFull = 4'(MaxHp);
  localparam logic [EnemyCount-1:0][3:0] HpInit = {EnemyCount{HpFull}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [BulletCount-1:0]          bvalid_q, bvalid_d;
  logic [BulletCount-1:0][9:0]     bx_q, bx_d;
  logic [BulletCount-1:0][9:0]     by_q, by_d;
  logic [BulletCount-1:0]          consumed_q, consumed_d;
  logic [BulletCount-1:0]          bhit_q, bhit_d;
  logic [EnemyCount-1:0]           ehit_q, ehit_d;
  logic [EnemyCount-1:0][3:0]      hp_q, hp_d;
  logic                            kill_valid_q, kill_valid_d;
  logic [IdxW-1:0]                 kill_idx_q, kill_idx_d;

  logic [10:0]                     ex11, ey11;
  logic [BulletCount-1:0]          overlap, eligible, winner;
  logic                            taken;

  // Hitbox test in 11 bits so edge sums near 1023 cannot wrap.
  always_comb begin
    ex11     = {1'b0, enemy_xpos_i[idx_q]};
    ey11     = {1'b0, enemy_ypos_i[idx_q]};
    overlap  = '0;
    eligible = '0;
    winner   = '0;
    taken    = 1'b0;
    for (int j = 0; j < BulletCount; j++) begin
      overlap[j] = (ex11 < {1'b0, bx_q[j]} + 11'(BulletBoxX0 + BulletBoxW)) &&
                   (ex11 + 11'(EnemyW) > {1'b0, bx_q[j]} + 11'(BulletBoxX0)) &&
                   (ey11 < {1'b0, by_q[j]} + 11'(BulletBoxY0 + BulletBoxH)) &&
                   (ey11 + 11'(EnemyH) > {1'b0, by_q[j]} + 11'(BulletBoxY0));
      eligible[j] = bvalid_q[j] && !consumed_q[j] && overlap[j] && !ehit_q[idx_q];
      winner[j]   = eligible[j] && !taken;
      taken       = taken || eligible[j];
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bvalid_d     = bvalid_q;
    bx_d         = bx_q;
    by_d         = by_q;
    consumed_d   = consumed_q;
    bhit_d       = bhit_q;
    ehit_d       = ehit_q;
    hp_d         = hp_q;
    kill_valid_d = 1'b0;
    kill_idx_d   = kill_idx_q;

    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          bvalid_d = bullet_valid_i;
          bx_d     = bullet_xpos_i;
          by_d     = bullet_ypos_i;
          for (int j = 0; j < BulletCount; j++) begin
            consumed_d[j] = (bullet_ypos_i[j] > 10'(ScreenH));
          end
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        consumed_d = consumed_q | winner;
        if (taken) begin
          hp_d[idx_q] = hp_q[idx_q] - 4'd1;
          if (hp_q[idx_q] == 4'd1) begin
            ehit_d[idx_q] = 1'b1;
            kill_valid_d  = 1'b1;
            kill_idx_d    = idx_q;
          end
        end
        if (idx_q == IdxW'(EnemyCount - 1)) begin
          bhit_d  = consumed_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new wave overrides any scan in flight, including a kill about to be reported.
    if (revive_i) begin
      state_d      = IDLE;
      hp_d         = HpInit;
      ehit_d       = '0;
      bhit_d       = '0;
      kill_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      bvalid_q     <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      consumed_q   <= '0;
      bhit_q       <= '0;
      ehit_q       <= '0;
      hp_q         <= HpInit;
      kill_valid_q <= 1'b0;
      kill_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bvalid_q     <= bvalid_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      consumed_q   <= consumed_d;
      bhit_q       <= bhit_d;
      ehit_q       <= ehit_d;
      hp_q         <= hp_d;
      kill_valid_q <= kill_valid_d;
      kill_idx_q   <= kill_idx_d;
    end
  end

  assign busy_o       = (state_q == SCAN);
  assign done_o       = (state_q == DONE);
  assign bhit_o       = bhit_q;
  assign ehit_o       = ehit_q;
  assign kill_valid_o = kill_valid_q;
  assign kill_idx_o   = kill_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_hit_scan.sv
// tb_hit_scan: two hit_scan instances (MaxHp 1 and 3) on shared stimulus,
// checked by a scoreboard fed from a frame-level reference model.
`default_nettype none

module tb_hit_scan;
  localparam int NB = 2;
  localparam int NE = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 frame_start, revive;
  logic [NB-1:0]        bv;
  logic [NB-1:0][9:0]   bx, by;
  logic [NE-1:0][9:0]   ex, ey;

  logic                 busy [2];
  logic                 dn   [2];
  logic                 kv   [2];
  logic [NB-1:0]        bh   [2];
  logic [NE-1:0]        eh   [2];
  logic [5:0]           ki   [2];

  hit_scan #(.MaxHp(1)) u_dut1 (
    .clk_i(clk), .reset_ni(rst_n), .frame_start_i(frame_start), .revive_i(revive),
    .bullet_valid_i(bv), .bullet_xpos_i(bx), .bullet_ypos_i(by),
    .enemy_xpos_i(ex), .enemy_ypos_i(ey),
    .busy_o(busy[0]), .done_o(dn[0]), .bhit_o(bh[0]), .ehit_o(eh[0]),
    .kill_valid_o(kv[0]), .kill_idx_o(ki[0]));

  hit_scan #(.MaxHp(3)) u_dut3 (
    .clk_i(clk), .reset_ni(rst_n), .frame_start_i(frame_start), .revive_i(revive),
    .bullet_valid_i(bv), .bullet_xpos_i(bx), .bullet_ypos_i(by),
    .enemy_xpos_i(ex), .enemy_ypos_i(ey),
    .busy_o(busy[1]), .done_o(dn[1]), .bhit_o(bh[1]), .ehit_o(eh[1]),
    .kill_valid_o(kv[1]), .kill_idx_o(ki[1]));

  typedef struct packed {
    logic [NB-1:0] bhit;
    logic [NE-1:0] ehit;
    logic [31:0]   cyc;
  } exp_t;

  int   kill_q [2][$];
  exp_t done_q [2][$];
  int   hp_m   [2][NE];
  int   max_hp [2] = '{1, 3};
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   mk;
  exp_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit overlaps(input int exv, input int eyv, input int bxv, input int byv);
    return (exv < bxv + 5 + 2) && (exv + 16 > bxv + 5) &&
           (eyv < byv + 3 + 8) && (eyv + 16 > byv + 3);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NE; i++) hp_m[k][i] = max_hp[k];
  endtask

  // Whole-frame result: enemies visited in order, first free overlapping bullet wins.
  task automatic model_scan(input int done_cyc);
    for (int k = 0; k < 2; k++) begin
      logic [NB-1:0] cons;
      exp_t e;
      for (int j = 0; j < NB; j++) cons[j] = (int'(by[j]) > 480);
      for (int i = 0; i < NE; i++) begin
        bit hit = 0;
        if (hp_m[k][i] > 0) begin
          for (int j = 0; j < NB; j++) begin
            if (!hit && bv[j] && !cons[j] &&
                overlaps(int'(ex[i]), int'(ey[i]), int'(bx[j]), int'(by[j]))) begin
              hit = 1;
              cons[j] = 1'b1;
              hp_m[k][i]--;
              if (hp_m[k][i] == 0) kill_q[k].push_back(i);
            end
          end
        end
      end
      e.bhit = cons;
      for (int i = 0; i < NE; i++) e.ehit[i] = (hp_m[k][i] == 0);
      e.cyc = 32'(done_cyc);
      done_q[k].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (kv[k]) begin
          if (kill_q[k].size() == 0) chk($sformatf("dut%0d unexpected kill idx", k), ki[k], 'hff);
          else begin
            mk = kill_q[k].pop_front();
            chk($sformatf("dut%0d kill idx", k), ki[k], mk);
          end
        end
        if (dn[k]) begin
          if (done_q[k].size() == 0) chk($sformatf("dut%0d unexpected done", k), dn[k], 0);
          else begin
            me = done_q[k].pop_front();
            chk($sformatf("dut%0d done cycle", k), cyc, me.cyc);
            chk($sformatf("dut%0d bhit", k), bh[k], me.bhit);
            chk($sformatf("dut%0d ehit", k), eh[k], me.ehit);
          end
        end
      end
    end
  end

  task automatic set_base(input bit jitter);
    for (int i = 0; i < NE; i++) begin
      ex[i] = 10'(300 + (i % 10) * 20 + (jitter ? int'($urandom_range(0, 4)) : 0));
      ey[i] = 10'(20 + (i / 10) * 30 + (jitter ? int'($urandom_range(0, 4)) : 0));
    end
  endtask

  // extra_at: offset in cycles after the start at which a second, ignored start is pulsed
  task automatic do_scan(input int extra_at);
    @(negedge clk);
    model_scan(cyc + 41);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int c = 1; c < 44; c++) begin
      if (c == extra_at) frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  endtask

  task automatic revive_idle(input bit with_start);
    @(negedge clk);
    revive = 1'b1;
    frame_start = with_start;
    @(negedge clk);
    revive = 1'b0;
    frame_start = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d busy after revive", k), busy[k], 0);
      chk($sformatf("dut%0d ehit after revive", k), eh[k], 0);
    end
  endtask

  task automatic revive_abort();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("dut%0d busy mid-scan", k), busy[k], 1);
    revive = 1'b1;
    @(negedge clk);
    revive = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d busy after abort", k), busy[k], 0);
      chk($sformatf("dut%0d ehit after abort", k), eh[k], 0);
      chk($sformatf("dut%0d kill pulse after abort", k), kv[k], 0);
    end
    repeat (45) @(negedge clk);
  endtask

  task automatic random_bullets();
    for (int j = 0; j < NB; j++) begin
      int t;
      t = int'($urandom_range(0, NE - 1));
      bv[j] = ($urandom_range(0, 3) != 0);
      bx[j] = 10'(int'(ex[t]) + int'($urandom_range(0, 20)) - 12);
      if ($urandom_range(0, 7) == 0) by[j] = 10'($urandom_range(470, 1023));
      else by[j] = 10'(int'(ey[t]) + int'($urandom_range(0, 24)) - 14);
    end
  endtask

  initial begin
    frame_start = 1'b0;
    revive = 1'b0;
    bv = '0;
    bx = '0;
    by = '0;
    set_base(0);
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d reset busy", k), busy[k], 0);
      chk($sformatf("dut%0d reset done", k), dn[k], 0);
      chk($sformatf("dut%0d reset kill_valid", k), kv[k], 0);
      chk($sformatf("dut%0d reset kill_idx", k), ki[k], 0);
      chk($sformatf("dut%0d reset bhit", k), bh[k], 0);
      chk($sformatf("dut%0d reset ehit", k), eh[k], 0);
    end
    rst_n = 1'b1;

    // single bullet on enemy 0
    set_base(0);
    ex[0] = 10'd96; ey[0] = 10'd200;
    bv = 2'b01; bx[0] = 10'd100; by[0] = 10'd200;
    do_scan(-1);

    // y = 480 stays on screen, y = 500 is pre-consumed
    set_base(0);
    bv = 2'b11; bx[0] = 10'd10; by[0] = 10'd480; bx[1] = 10'd10; by[1] = 10'd500;
    do_scan(-1);

    // both bullets overlap adjacent enemies 5 and 6
    set_base(0);
    ex[5] = 10'd200; ey[5] = 10'd100; ex[6] = 10'd210; ey[6] = 10'd100;
    bv = 2'b11; bx[0] = 10'd206; by[0] = 10'd100; bx[1] = 10'd206; by[1] = 10'd100;
    do_scan(-1);

    // repeated hits on enemy 2; extra starts during SCAN and DONE
    set_base(0);
    ex[2] = 10'd150; ey[2] = 10'd300;
    bv = 2'b01; bx[0] = 10'd145; by[0] = 10'd300; by[1] = 10'd0;
    do_scan(-1);
    do_scan(10);
    do_scan(41);

    // revive lands while enemy 20 is being hit
    set_base(0);
    ex[20] = 10'd250; ey[20] = 10'd200;
    bv = 2'b01; bx[0] = 10'd245; by[0] = 10'd200;
    revive_abort();
    do_scan(-1);

    revive_idle(1);
    repeat (45) @(negedge clk);

    for (int s = 0; s < 30; s++) begin
      set_base(1);
      random_bullets();
      if ($urandom_range(0, 7) == 0) revive_idle(1'($urandom_range(0, 1)));
      do_scan(-1);
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d missing kills", k), kill_q[k].size(), 0);
      chk($sformatf("dut%0d missing dones", k), done_q[k].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
